param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath, register and bus width in bits (4..16).
REQ-002 SHALL have parameter DEPTH, default 8: register file entries, power of two.
REQ-003 SHALL have parameter DIGITS, default 3: decimal display digits.
REQ-004 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports reg_add in $clog2(DEPTH), RNW in 1 (1=read, 0=write), BS in 3 (bus mux select), WrA/WrB in 1 (buffer load enables).
REQ-007 SHALL have ports ALUop in 3 (operation), start in 1 (operation request), busy out 1, done out 1 (one-cycle completion pulse), ovf out 1 (carry/borrow/overflow flag).
REQ-008 SHALL have ports ALUout, A_out, B_out, Multiplexer_out and Register_out, each out WIDTH.
REQ-009 SHALL have port disp_drv out 7*DIGITS: active-low seven-segment drive, digit 0 (units) in bits [6:0].

Function
REQ-010 Bus mux SHALL be registered: BS 0/1/2/3 -> 0/1/2/4; 4 -> Register_out; 5 -> ALUout; 6/7 -> 0.
REQ-011 Register file SHALL write Multiplexer_out to R[reg_add] when RNW=0; when RNW=1 it SHALL register R[reg_add] onto Register_out; both are allowed in any FSM state.
REQ-012 When idle, WrA=1 SHALL load A from Multiplexer_out; WrB=1 with WrA=0 SHALL load B; WrA has priority; both are ignored while busy.
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, CONV and DONE; busy=1 in every state except IDLE.
REQ-014 start sampled in IDLE SHALL latch ALUop and go to EXEC (op 6 -> MUL); start in any other state SHALL be ignored.
REQ-015 EXEC SHALL take 1 cycle and write the result: 0 nop (ALUout held, go IDLE, no done), 1 A+B, 2 A-B, 3 A+1, 4 A-1, 5 A&B, 7 A^B; results SHALL be modulo 2^WIDTH.
REQ-016 ovf SHALL equal carry-out for ops 1/3, borrow for ops 2/4, nonzero upper product half for op 6, and 0 otherwise.
REQ-017 MUL SHALL be shift-add over exactly WIDTH cycles; ALUout SHALL be the low WIDTH bits of the product.
REQ-018 CONV SHALL run double-dabble binary-to-BCD over ALUout for exactly WIDTH cycles, then go to DONE; DONE SHALL last one cycle (done=1) and then return to IDLE.
REQ-019 disp_drv SHALL update only on entry to DONE; digit patterns 0-9 = 3F,06,5B,4F,66,6D,7C,07,7F,67 (segments lit), inverted on output.
REQ-020 If ALUout >= 10^DIGITS, every digit SHALL show 'F' (7'b1110001 lit).
REQ-021 Timing with start sampled at edge 0: ALUout SHALL update at edge 1 (op 6: edge WIDTH); done SHALL rise at edge WIDTH+2 (op 6: 2*WIDTH+1).

Reset
REQ-022 Reset SHALL be effective at any time, including mid-MUL/CONV: FSM to IDLE, all registers, A, B, ALUout, Multiplexer_out, Register_out to 0, busy=done=ovf=0, every digit showing '0' (7'h40 per digit).

Configuration
REQ-023 Macro PARAM_DATAPATH_MUL_EN defined SHALL include the MUL state and shift-add multiplier.
REQ-024 Without PARAM_DATAPATH_MUL_EN, op 6 SHALL execute in EXEC with ALUout=0 and ovf=0, no multiplier logic synthesised.

Structure
REQ-025 Package datapath_pkg SHALL hold the ALU op enum, FSM state enum, segment pattern constants and the 'F' constant.
REQ-026 Sub-module seg7_enc (4-bit BCD -> active-low 7-segment, combinational) SHALL be instantiated DIGITS times.

Verification (WIDTH=8, DEPTH=8, DIGITS=3 unless noted)
REQ-027 Reset mid-CONV -> busy=0 next cycle, ALUout=0, disp_drv=21'h102040 (all '0').
REQ-028 A=25, B=17, op 1, start -> ALUout=42 at edge 1, done at edge 10, digits 0/4/2, ovf=0.
REQ-029 A=3, B=5, op 2 -> ALUout=254, ovf=1, display "254"; start pulsed at edge 3 ignored.
REQ-030 A=20, B=13, op 6 with macro -> ALUout=4, ovf=1, done at edge 17; without macro -> ALUout=0, done at edge 10.
REQ-031 BS=3, RNW=0, reg_add=5, then RNW=1 -> Register_out=4; route BS=4 then WrA -> A_out=4.
REQ-032 DIGITS=2, A=200, op 3 -> ALUout=201, both digits 'F'.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types and constants for param_datapath: ALU opcodes, FSM states and
// seven-segment patterns (segments lit = 1, bit 0 = segment a).
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_INC = 3'd3,
    OP_DEC = 3'd4,
    OP_AND = 3'd5,
    OP_MUL = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    CONV,
    DONE
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7C;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_lit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// One BCD digit to active-low seven-segment drive; non-decimal codes go blank.
module seg7_enc
  import datapath_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  assign seg_n = ~seg_lit(bcd);

endmodule

// File: rtl/param_datapath.sv
// Bus mux, register file, A/B buffers, sequenced ALU with BCD display readout.
// Define PARAM_DATAPATH_MUL_EN to include the shift-add multiplier (op 6).
module param_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(DEPTH)-1:0]   reg_add,
  input  logic                       RNW,
  input  logic [2:0]                 BS,
  input  logic                       WrA,
  input  logic                       WrB,
  input  logic [2:0]                 ALUop,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf,
  output logic [WIDTH-1:0]           ALUout,
  output logic [WIDTH-1:0]           A_out,
  output logic [WIDTH-1:0]           B_out,
  output logic [WIDTH-1:0]           Multiplexer_out,
  output logic [WIDTH-1:0]           Register_out,
  output logic [7*DIGITS-1:0]        disp_drv
);

  // BCD buffer always holds at least 5 digits, enough for any 16-bit value,
  // so digits beyond DIGITS reveal display overflow.
  localparam int NB = (DIGITS > 5) ? DIGITS : 5;
  localparam int CW = $clog2(WIDTH + 1);

  state_e             state, state_nx;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   rf [DEPTH];
  logic [CW-1:0]      cnt;
  logic [4*NB-1:0]    bcd;
  logic [WIDTH:0]     ex_res;
  logic               conv_bit;
  logic               over;
  logic [7*DIGITS-1:0] seg_n;
  logic [7*DIGITS-1:0] disp_nx;

  function automatic logic [4*NB-1:0] dabble(input logic [4*NB-1:0] v, input logic b);
    logic [4*NB-1:0] t;
    t = v;
    for (int i = 0; i < NB; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[4*NB-2:0], b};
  endfunction

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    ex_res = '0;
    case (op_q)
      OP_ADD:  ex_res = {1'b0, A_out} + {1'b0, B_out};
      OP_SUB:  ex_res = {1'b0, A_out} - {1'b0, B_out};
      OP_INC:  ex_res = {1'b0, A_out} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  ex_res = {1'b0, A_out} - {{WIDTH{1'b0}}, 1'b1};
      OP_AND:  ex_res = {1'b0, A_out & B_out};
      OP_XOR:  ex_res = {1'b0, A_out ^ B_out};
      default: ex_res = '0;
    endcase
  end

  // Conversion consumes ALUout MSB first, one bit per CONV cycle.
  always_comb begin
    conv_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(WIDTH - 1 - i) == cnt) conv_bit = ALUout[i];
    end
  end

  always_comb begin
    over = 1'b0;
    for (int i = DIGITS; i < NB; i++) begin
      over = over | (bcd[4*i +: 4] != 4'd0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_enc u_seg (
      .bcd   (bcd[4*g +: 4]),
      .seg_n (seg_n[7*g +: 7])
    );
  end

  assign disp_nx = over ? {DIGITS{~SEG_F}} : seg_n;

`ifdef PARAM_DATAPATH_MUL_EN
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH:0]     psum;

  always_comb begin
    psum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, A_out} : {(WIDTH+1){1'b0}});
    prod_nx = {psum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod <= '0;
    end else if (state == IDLE && start && ALUop == OP_MUL) begin
      prod <= {{WIDTH{1'b0}}, B_out};
    end else if (state == MUL) begin
      prod <= prod_nx;
    end
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef PARAM_DATAPATH_MUL_EN
          state_nx = (ALUop == OP_MUL) ? MUL : EXEC;
`else
          state_nx = EXEC;
`endif
        end
      end
      EXEC: state_nx = (op_q == OP_NOP) ? IDLE : CONV;
`ifdef PARAM_DATAPATH_MUL_EN
      MUL:  if (cnt == CW'(WIDTH - 1)) state_nx = CONV;
`endif
      CONV: if (cnt == CW'(WIDTH)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      op_q            <= OP_NOP;
      A_out           <= '0;
      B_out           <= '0;
      ALUout          <= '0;
      ovf             <= 1'b0;
      Multiplexer_out <= '0;
      Register_out    <= '0;
      cnt             <= '0;
      bcd             <= '0;
      disp_drv        <= {DIGITS{7'h40}};
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;

      case (BS)
        3'd0:    Multiplexer_out <= '0;
        3'd1:    Multiplexer_out <= WIDTH'(1);
        3'd2:    Multiplexer_out <= WIDTH'(2);
        3'd3:    Multiplexer_out <= WIDTH'(4);
        3'd4:    Multiplexer_out <= Register_out;
        3'd5:    Multiplexer_out <= ALUout;
        default: Multiplexer_out <= '0;
      endcase

      if (!RNW) rf[reg_add] <= Multiplexer_out;
      else      Register_out <= rf[reg_add];

      if (state == IDLE) begin
        if (WrA)      A_out <= Multiplexer_out;
        else if (WrB) B_out <= Multiplexer_out;
        if (start) begin
          op_q <= alu_op_e'(ALUop);
          cnt  <= '0;
        end
      end

      case (state)
        EXEC: begin
          ovf <= ex_res[WIDTH];
          if (op_q != OP_NOP) begin
            ALUout <= ex_res[WIDTH-1:0];
            cnt    <= '0;
            bcd    <= '0;
          end
        end
`ifdef PARAM_DATAPATH_MUL_EN
        MUL: begin
          if (cnt == CW'(WIDTH - 1)) begin
            ALUout <= prod_nx[WIDTH-1:0];
            ovf    <= |prod_nx[2*WIDTH-1:WIDTH];
            cnt    <= '0;
            bcd    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        CONV: begin
          if (cnt == CW'(WIDTH)) begin
            disp_drv <= disp_nx;
          end else begin
            bcd <= dabble(bcd, conv_bit);
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath (WIDTH=8, DEPTH=8) with 3- and 2-digit displays.
module tb_param_datapath;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] reg_add = '0;
  logic       RNW = 1'b1;
  logic [2:0] BS = '0;
  logic       WrA = 1'b0;
  logic       WrB = 1'b0;
  logic [2:0] ALUop = '0;
  logic       start = 1'b0;

  logic        busy, done, ovf;
  logic [7:0]  alu, a_o, b_o, mux_o, reg_o;
  logic [20:0] disp;

  logic        busy2, done2, ovf2;
  logic [7:0]  alu2, a2, b2, mux2, reg2;
  logic [13:0] disp2;

  int errs = 0;
  int checks = 0;

  param_datapath #(.WIDTH(8), .DEPTH(8), .DIGITS(3)) dut (
    .clock(clock), .reset(reset), .reg_add(reg_add), .RNW(RNW), .BS(BS),
    .WrA(WrA), .WrB(WrB), .ALUop(ALUop), .start(start), .busy(busy),
    .done(done), .ovf(ovf), .ALUout(alu), .A_out(a_o), .B_out(b_o),
    .Multiplexer_out(mux_o), .Register_out(reg_o), .disp_drv(disp)
  );

  param_datapath #(.WIDTH(8), .DEPTH(8), .DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .reg_add(reg_add), .RNW(RNW), .BS(BS),
    .WrA(WrA), .WrB(WrB), .ALUop(ALUop), .start(start), .busy(busy2),
    .done(done2), .ovf(ovf2), .ALUout(alu2), .A_out(a2), .B_out(b2),
    .Multiplexer_out(mux2), .Register_out(reg2), .disp_drv(disp2)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] lit(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7C; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h67;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] exp3(input int h, input int t, input int u);
    return {~lit(h), ~lit(t), ~lit(u)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mux(input logic [2:0] s);
    BS = s;
    tick();
  endtask

  task automatic wr_a();
    WrA = 1'b1; tick(); WrA = 1'b0;
  endtask

  task automatic wr_b();
    WrB = 1'b1; tick(); WrB = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op);
    int n;
    ALUop = op; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errs++;
      $display("FAIL run_op_timeout: op %0d never reached done within %0d cycles", op, n);
    end
    tick();
  endtask

  // Leaves v in ALUout using only doubling (A+A) and increment.
  task automatic build(input int v);
    set_mux(3'd0); wr_a(); wr_b(); run_op(3'd1);
    for (int i = 7; i >= 0; i--) begin
      set_mux(3'd5); wr_a(); wr_b(); run_op(3'd1);
      if (v[i]) begin
        set_mux(3'd5); wr_a(); run_op(3'd3);
      end
    end
  endtask

  task automatic load_ab(input int a, input int b);
    build(b);
    set_mux(3'd5); reg_add = 3'd1; RNW = 1'b0; tick(); RNW = 1'b1;
    build(a);
    set_mux(3'd5); wr_a();
    reg_add = 3'd1; tick();
    set_mux(3'd4); wr_b();
    checks++;
    if (a_o !== 8'(a)) begin errs++; $display("FAIL load_a: got %0d want %0d", a_o, a); end
    checks++;
    if (b_o !== 8'(b)) begin errs++; $display("FAIL load_b: got %0d want %0d", b_o, b); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {busy, done, ovf}); end
    checks++;
    if ({alu, a_o, b_o, mux_o, reg_o} !== 40'h0) begin errs++; $display("FAIL reset_regs: got %h want 0", {alu, a_o, b_o, mux_o, reg_o}); end
    checks++;
    if (disp !== 21'h102040) begin errs++; $display("FAIL reset_disp: got %h want 102040", disp); end
  endtask

  task automatic test_regfile();
    set_mux(3'd3);
    checks++;
    if (mux_o !== 8'd4) begin errs++; $display("FAIL mux_bs3: got %0d want 4", mux_o); end
    reg_add = 3'd5; RNW = 1'b0; tick();
    RNW = 1'b1; tick();
    checks++;
    if (reg_o !== 8'd4) begin errs++; $display("FAIL reg_read5: got %0d want 4", reg_o); end
    set_mux(3'd4); wr_a();
    checks++;
    if (a_o !== 8'd4) begin errs++; $display("FAIL route_to_a: got %0d want 4", a_o); end
  endtask

  task automatic test_add();
    load_ab(25, 17);
    ALUop = 3'd1; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL add_busy: got %b want 1", busy); end
    tick();
    checks++;
    if (alu !== 8'd42) begin errs++; $display("FAIL add_edge1: got %0d want 42", alu); end
    repeat (8) tick();
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL add_done_early: got %b want 0 at edge 9", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errs++; $display("FAIL add_done_edge10: got %b want 1", done); end
    checks++;
    if (disp !== exp3(0, 4, 2)) begin errs++; $display("FAIL add_disp: got %h want %h", disp, exp3(0, 4, 2)); end
    checks++;
    if (ovf !== 1'b0) begin errs++; $display("FAIL add_ovf: got %b want 0", ovf); end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin errs++; $display("FAIL add_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_sub();
    load_ab(3, 5);
    ALUop = 3'd2; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (alu !== 8'd254) begin errs++; $display("FAIL sub_edge1: got %0d want 254", alu); end
    checks++;
    if (ovf !== 1'b1) begin errs++; $display("FAIL sub_borrow: got %b want 1", ovf); end
    tick();
    ALUop = 3'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL sub_done_early: got %b want 0 at edge 9", done); end
    tick();
    checks++;
    if (done !== 1'b1 || alu !== 8'd254) begin errs++; $display("FAIL sub_done: got done=%b alu=%0d want 1/254", done, alu); end
    checks++;
    if (disp !== exp3(2, 5, 4)) begin errs++; $display("FAIL sub_disp: got %h want %h", disp, exp3(2, 5, 4)); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL sub_start_ignored: got busy %b want 0", busy); end
  endtask

  task automatic test_mul();
    load_ab(20, 13);
    ALUop = 3'd6; start = 1'b1; tick(); start = 1'b0;
`ifdef PARAM_DATAPATH_MUL_EN
    repeat (7) tick();
    checks++;
    if (alu !== 8'd20) begin errs++; $display("FAIL mul_edge7: got %0d want 20 (unchanged)", alu); end
    tick();
    checks++;
    if (alu !== 8'd4 || ovf !== 1'b1) begin errs++; $display("FAIL mul_edge8: got alu=%0d ovf=%b want 4/1", alu, ovf); end
    repeat (8) tick();
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL mul_done_early: got %b want 0 at edge 16", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errs++; $display("FAIL mul_done_edge17: got %b want 1", done); end
    checks++;
    if (disp !== exp3(0, 0, 4)) begin errs++; $display("FAIL mul_disp: got %h want %h", disp, exp3(0, 0, 4)); end
`else
    tick();
    checks++;
    if (alu !== 8'd0 || ovf !== 1'b0) begin errs++; $display("FAIL mul_off_edge1: got alu=%0d ovf=%b want 0/0", alu, ovf); end
    repeat (8) tick();
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL mul_off_done_early: got %b want 0 at edge 9", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errs++; $display("FAIL mul_off_done_edge10: got %b want 1", done); end
    checks++;
    if (disp !== exp3(0, 0, 0)) begin errs++; $display("FAIL mul_off_disp: got %h want %h", disp, exp3(0, 0, 0)); end
`endif
    tick();
  endtask

  task automatic test_logic();
    int n;
    load_ab(165, 60);
    ALUop = 3'd7; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (alu !== 8'd153 || ovf !== 1'b0) begin errs++; $display("FAIL xor: got alu=%0d ovf=%b want 153/0", alu, ovf); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin errs++; $display("FAIL xor_done_timeout: got done %b want 1", done); end
    tick();
    ALUop = 3'd5; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (alu !== 8'd36) begin errs++; $display("FAIL and: got %0d want 36", alu); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
  endtask

  task automatic test_digits2();
    build(200);
    set_mux(3'd5); wr_a(); run_op(3'd3);
    checks++;
    if (alu !== 8'd201 || alu2 !== 8'd201) begin errs++; $display("FAIL inc201: got %0d/%0d want 201", alu, alu2); end
    checks++;
    if (disp2 !== {2{~7'b1110001}}) begin errs++; $display("FAIL disp2_overflow: got %h want %h", disp2, {2{~7'b1110001}}); end
    checks++;
    if (disp !== exp3(2, 0, 1)) begin errs++; $display("FAIL disp3_201: got %h want %h", disp, exp3(2, 0, 1)); end
  endtask

  task automatic test_reset_conv();
    ALUop = 3'd1; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL conv_busy: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf} !== 3'b000 || alu !== 8'd0) begin errs++; $display("FAIL async_reset: got flags=%b alu=%0d want 000/0", {busy, done, ovf}, alu); end
    checks++;
    if (disp !== 21'h102040) begin errs++; $display("FAIL async_reset_disp: got %h want 102040", disp); end
    tick();
    reset = 1'b0;
    reg_add = 3'd5; RNW = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || reg_o !== 8'd0 || a_o !== 8'd0) begin errs++; $display("FAIL post_reset: got busy=%b R5=%0d A=%0d want 0/0/0", busy, reg_o, a_o); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_add();
    test_sub();
    test_mul();
    test_logic();
    test_digits2();
    test_reset_conv();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
